alu_mul_seq: RTL and testbench

- Multi-cycle shift-add multiplier sequencer that drives the shared 16-bit combinational ALU through its opcode/operand inputs and captures its result.
- Produces the low 16 bits of an unsigned 16x16 product, using ALU opcode 000 (add) and 010 (shift left, result = regb << rega).
- Sits beside the ALU in the datapath. The control unit issues start and stalls the pipeline while busy is high.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/alu_mul_seq.sv | 148 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: ALU opcodes, data width and the
// state encoding used by the shift-add multiply sequencer.
package cpu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier sequencer: borrows the shared ALU for add and
// shift-left steps and returns the low 16 bits of op_a*op_b.
module alu_mul_seq
  import cpu_pkg::*;
#(
  parameter int EARLY_EXIT = 1,
  parameter int ITER       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result
);

  mul_state_e        state_r;
  mul_state_e        state_s;
  logic [DATA_W-1:0] m_r;
  logic [DATA_W-1:0] q_r;
  logic [DATA_W-1:0] p_r;
  logic [4:0]        cnt_r;
  logic [DATA_W-1:0] product_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] q_shr_s;
  logic              last_iter_s;

  assign q_shr_s     = q_r >> 1;
  // the right shift is local because the ALU only shifts left
  assign last_iter_s = (cnt_r == 5'(ITER - 1)) ||
                       ((EARLY_EXIT != 0) && (q_shr_s == {DATA_W{1'b0}}));

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((op_b == {DATA_W{1'b0}}) && (EARLY_EXIT != 0)) begin
            state_s = ST_DONE;
          end else if (op_b[0]) begin
            state_s = ST_ADD;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        state_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_iter_s) begin
          state_s = ST_DONE;
        end else if (q_shr_s[0]) begin
          state_s = ST_ADD;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // ALU operand/opcode drive, decoded straight from the current state
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = {DATA_W{1'b0}};
    alu_b  = {DATA_W{1'b0}};
    case (state_r)
      ST_ADD: begin
        alu_op = ALU_ADD;
        alu_a  = p_r;
        alu_b  = m_r;
      end
      ST_SHIFT: begin
        alu_op = ALU_SHL;
        alu_a  = 16'd1;
        alu_b  = m_r;
      end
      default: begin
        alu_op = ALU_ADD;
        alu_a  = {DATA_W{1'b0}};
        alu_b  = {DATA_W{1'b0}};
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      m_r       <= {DATA_W{1'b0}};
      q_r       <= {DATA_W{1'b0}};
      p_r       <= {DATA_W{1'b0}};
      cnt_r     <= 5'd0;
      product_r <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            m_r   <= op_a;
            q_r   <= op_b;
            p_r   <= {DATA_W{1'b0}};
            cnt_r <= 5'd0;
          end
        end
        ST_ADD: begin
          p_r <= alu_result;
        end
        ST_SHIFT: begin
          m_r   <= alu_result;
          q_r   <= q_shr_s;
          cnt_r <= cnt_r + 5'd1;
        end
        ST_DONE: begin
          product_r <= p_r;
        end
        default: begin
          product_r <= product_r;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (early exit on and off), each wired
// to a behavioural model of the shared ALU.
module tb_alu_mul_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start0;
  logic [15:0] a1, b1, a0, b0;
  logic        busy1, done1, busy0, done0;
  logic [15:0] product1, product0;
  logic [2:0]  aop1, aop0;
  logic [15:0] ra1, rb1, res1, ra0, rb0, res0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3'b000:  alu_f = x + y;
      3'b010:  alu_f = y << x;
      default: alu_f = 16'd0;
    endcase
  endfunction

  assign res1 = alu_f(aop1, ra1, rb1);
  assign res0 = alu_f(aop0, ra0, rb0);

  alu_mul_seq #(.EARLY_EXIT(1), .ITER(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .product(product1),
    .alu_op(aop1), .alu_a(ra1), .alu_b(rb1), .alu_result(res1));

  alu_mul_seq #(.EARLY_EXIT(0), .ITER(16)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(a0), .op_b(b0),
    .busy(busy0), .done(done0), .product(product0),
    .alu_op(aop0), .alu_a(ra0), .alu_b(rb0), .alu_result(res0));

  bit          sel = 1'b1;
  logic        cur_busy, cur_done;
  logic [15:0] cur_prod, cur_a, cur_b;
  logic [2:0]  cur_op;
  assign cur_busy = sel ? busy1 : busy0;
  assign cur_done = sel ? done1 : done0;
  assign cur_prod = sel ? product1 : product0;
  assign cur_op   = sel ? aop1 : aop0;
  assign cur_a    = sel ? ra1 : ra0;
  assign cur_b    = sel ? rb1 : rb0;

  typedef struct {
    bit          ee;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit ee, input bit s, input logic [15:0] a, input logic [15:0] b);
    if (ee) begin
      start1 = s; a1 = a; b1 = b;
    end else begin
      start0 = s; a0 = a; b0 = b;
    end
  endtask

  // Wait (bounded) for done; returns cycles elapsed since the accepting edge.
  task automatic wait_done(input int n0, output int n, output bit got);
    n = n0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (cur_done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input bit ee, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] prod, input int lat);
    logic [2:0]  eop[$];
    logic [15:0] ea[$];
    logic [15:0] eb[$];
    logic [15:0] m, q, p;
    int          cnt, n, bsy, terr;
    bit          got, in_add, fin;
    exp_t        e;
    // independent trace model of the expected ALU drive
    m = a; q = b; p = 16'd0; cnt = 0; fin = 1'b0;
    if (ee && q == 16'd0) fin = 1'b1;
    in_add = q[0];
    while (!fin) begin
      if (in_add) begin
        eop.push_back(3'b000); ea.push_back(p); eb.push_back(m);
        p = p + m;
        in_add = 1'b0;
      end else begin
        eop.push_back(3'b010); ea.push_back(16'd1); eb.push_back(m);
        m = m << 1; q = q >> 1; cnt++;
        if (cnt == 16 || (ee && q == 16'd0)) fin = 1'b1;
        else in_add = q[0];
      end
    end
    eop.push_back(3'b000); ea.push_back(16'd0); eb.push_back(16'd0);

    sel = ee;
    @(negedge clk);
    drive(ee, 1'b1, a, b);
    sb.push_back('{prod, lat});
    @(posedge clk);
    #1 drive(ee, 1'b0, a, b);
    n = 0; bsy = 0; terr = 0; got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (cur_busy) bsy++;
      if (n <= eop.size()) begin
        if (cur_op !== eop[n-1] || cur_a !== ea[n-1] || cur_b !== eb[n-1]) terr++;
      end else begin
        terr++;
      end
      if (cur_done) got = 1'b1;
    end
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("busy_cycles", bsy, e.lat);
      chk("alu_trace", terr, 0);
      @(negedge clk);
      chk("product", 32'(cur_prod), 32'(e.prod));
      chk("done_pulse_end", 32'(cur_done), 32'd0);
      chk("idle_after", 32'(cur_busy), 32'd0);
    end
  endtask

  vec_t vecs[11];

  initial begin
    int  n;
    bit  got;
    vecs[0]  = '{1'b1, 16'd3,      16'd5,      16'd15,     6};
    vecs[1]  = '{1'b1, 16'h1234,   16'h0000,   16'h0000,   1};
    vecs[2]  = '{1'b1, 16'hFFFF,   16'hFFFF,   16'h0001,   33};
    vecs[3]  = '{1'b1, 16'h0100,   16'h0101,   16'h0100,   12};
    vecs[4]  = '{1'b1, 16'hABCD,   16'h0001,   16'hABCD,   3};
    vecs[5]  = '{1'b1, 16'h0001,   16'h8000,   16'h8000,   18};
    vecs[6]  = '{1'b1, 16'h0002,   16'h8000,   16'h0000,   18};
    vecs[7]  = '{1'b1, 16'd7,      16'd7,      16'd49,     7};
    vecs[8]  = '{1'b0, 16'd3,      16'd5,      16'd15,     19};
    vecs[9]  = '{1'b0, 16'h1234,   16'h0000,   16'h0000,   17};
    vecs[10] = '{1'b0, 16'h00FF,   16'h0003,   16'h02FD,   19};

    reset = 1'b1;
    drive(1'b1, 1'b0, 16'd0, 16'd0);
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_product", 32'(product1), 32'd0);
    chk("rst_alu", {13'd0, aop1, ra1 | rb1}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy1 | busy0), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].ee, vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].lat);
    end

    // start while busy and start during DONE are both ignored
    sel = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 16'd3, 16'd5);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 16'd3, 16'd5);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 1'b1, 16'd7, 16'd7);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 16'd7, 16'd7);
    wait_done(2, n, got);
    if (got) begin
      chk("busy_start_latency", n, 6);
      drive(1'b1, 1'b1, 16'd9, 16'd9);
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 16'd9, 16'd9);
      @(negedge clk);
      chk("busy_start_product", 32'(product1), 32'd15);
      chk("done_start_ignored", 32'(busy1), 32'd0);
    end
    run_op(1'b1, 16'd7, 16'd7, 16'd49, 7);

    // reset in the middle of a long multiply
    sel = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("mid_busy_before_reset", 32'(busy1), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_product", 32'(product1), 32'd0);
    chk("mid_rst_alu", {13'd0, aop1, ra1 | rb1}, 32'd0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (done1) n++;
    end
    reset = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (done1 | busy1) n++;
    end
    chk("mid_rst_no_done", n, 0);
    run_op(1'b1, 16'd2, 16'd3, 16'd6, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
